// File: rtl/event_pacer.sv
// -----------------------------------------------------------------------------
// event_pacer
//
// Upstream feeder for the 4-bit event counter.
//   - Accepts event requests on a valid/ready handshake and queues them as a
//     pending count P (0..DEPTH).
//   - Emits one registered single-cycle `en` pulse per queued event.
//   - Consecutive pulses are spaced at least GAP cycles apart.
//   - Issue stalls while the downstream counter reports `cnt_full`.
//
// Parameters:
//   DEPTH : maximum pending events (1..15).
//   GAP   : minimum spacing in cycles between `en` pulses (1..15).
//
// Ports:
//   clk      in   single clock, all logic on posedge
//   rst      in   synchronous, active-low reset
//   ev_valid in   upstream event request
//   ev_ready out  pacer can accept an event this cycle
//   cnt_full in   downstream counter saturated, inhibits issue
//   en       out  registered one-cycle increment pulse to the counter
//   pending  out  current pending count P, zero-extended to 4 bits
//   dropped  out  sticky drop flag (only with EVENT_PACER_DROP_EN)
//
// Build option:
//   EVENT_PACER_DROP_EN
//     Defined   : always ready out of reset. An event arriving with P==DEPTH
//                 and no issue at that edge is discarded and sets `dropped`.
//     Undefined : plain backpressure, no event is ever lost, no `dropped` port.
// -----------------------------------------------------------------------------
module event_pacer #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ev_valid,
  output logic       ev_ready,
  input  logic       cnt_full,
  output logic       en,
  output logic [3:0] pending
`ifdef EVENT_PACER_DROP_EN
  ,
  output logic       dropped
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic [3:0] GAP_M1  = 4'(GAP - 1);

  state_t     r_state;
  logic [3:0] r_p;
  logic [3:0] r_gap_cnt;
  logic       r_en;

  logic       w_at_depth;
  logic       w_issue;
  logic       w_take;

  // P never exceeds DEPTH, so equality is the full test.
  assign w_at_depth = (r_p == DEPTH_C);

  // Issue decision is made only from IDLE; cnt_full is looked at only here,
  // so a pulse already launched always completes.
  assign w_issue = (r_state == IDLE) && !cnt_full && (r_p != 4'd0);

`ifdef EVENT_PACER_DROP_EN
  logic r_dropped;
  logic w_drop;

  assign ev_ready = rst;
  // At DEPTH an event still fits if a slot is freed by an issue at this edge.
  assign w_take   = ev_valid && (!w_at_depth || w_issue);
  assign w_drop   = ev_valid && w_at_depth && !w_issue;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dropped <= 1'b0;
    end else if (w_drop) begin
      r_dropped <= 1'b1;
    end
  end

  assign dropped = r_dropped;
`else
  // Readiness comes only from registered P: no same-cycle pass-through at DEPTH.
  assign ev_ready = rst && !w_at_depth;
  assign w_take   = ev_valid && ev_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_p       <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_en      <= 1'b0;
    end else begin
      // Accept and issue at the same edge cancel out.
      r_p  <= r_p + {3'd0, w_take} - {3'd0, w_issue};
      r_en <= w_issue;
      unique case (r_state)
        IDLE: begin
          if (cnt_full) begin
            r_state <= HOLD;
          end else if (r_p != 4'd0) begin
            r_gap_cnt <= GAP_M1;
            r_state   <= (GAP == 1) ? IDLE : WAIT;
          end
        end
        WAIT: begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
          if (r_gap_cnt == 4'd1) begin
            r_state <= IDLE;
          end
        end
        HOLD: begin
          // Return to IDLE first; the issue decision happens on the next edge.
          if (!cnt_full) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign en      = r_en;
  assign pending = r_p;

endmodule

// File: tb/tb_event_pacer.sv
// -----------------------------------------------------------------------------
// tb_event_pacer
//
// Two instances share the input stimulus: u_dut0 (DEPTH=4, GAP=2) and
// u_dut1 (DEPTH=4, GAP=1). Each instance is tracked by a reference model
// expressed as "earliest edge at which the next issue may be considered"
// plus a hold flag, and every cycle is compared against it. Directed table
// rows and hand sequences add fixed expected values for the corner cases.
// -----------------------------------------------------------------------------
module tb_event_pacer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       ev_valid;
  logic       cnt_full;
  logic       ev_ready0, ev_ready1;
  logic       en0, en1;
  logic [3:0] pending0, pending1;
`ifdef EVENT_PACER_DROP_EN
  logic       dropped0, dropped1;
`endif

  event_pacer #(.DEPTH(DEPTH), .GAP(2)) u_dut0 (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready0),
    .cnt_full (cnt_full),
    .en       (en0),
    .pending  (pending0)
`ifdef EVENT_PACER_DROP_EN
    ,
    .dropped  (dropped0)
`endif
  );

  event_pacer #(.DEPTH(DEPTH), .GAP(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready1),
    .cnt_full (cnt_full),
    .en       (en1),
    .pending  (pending1)
`ifdef EVENT_PACER_DROP_EN
    ,
    .dropped  (dropped1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n     = 0;

  // Reference model state, index 0 -> GAP=2 instance, index 1 -> GAP=1.
  int gaps [2] = '{2, 1};
  int m_p   [2];
  int m_next[2];
  bit m_held[2];
  bit m_en  [2];
  bit m_drop[2];
  bit rdy_s [2];
  int acc_cnt = 0;
  int en_cnt  = 0;

`ifdef EVENT_PACER_DROP_EN
  localparam bit DROP_MODE = 1'b1;
`else
  localparam bit DROP_MODE = 1'b0;
`endif

  typedef struct {
    logic       r;
    logic       v;
    logic       f;
    logic       e_en;
    logic [3:0] e_p;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, n);
    end
  endtask

  // Behavioural model for one clock edge.
  task automatic model_edge(input bit r, input bit v, input bit f);
    for (int i = 0; i < 2; i++) begin
      bit iss;
      bit take;
      if (!r) begin
        m_p[i]    = 0;
        m_next[i] = 0;
        m_held[i] = 1'b0;
        m_en[i]   = 1'b0;
        m_drop[i] = 1'b0;
      end else begin
        iss = 1'b0;
        if (m_held[i]) begin
          if (!f) begin
            m_held[i] = 1'b0;
            m_next[i] = n + 1;
          end
        end else if (n >= m_next[i]) begin
          if (f) begin
            m_held[i] = 1'b1;
          end else if (m_p[i] > 0) begin
            iss       = 1'b1;
            m_next[i] = n + gaps[i];
          end
        end
        if (DROP_MODE) take = v && (m_p[i] < DEPTH || iss);
        else           take = v && (m_p[i] < DEPTH);
        if (DROP_MODE && v && !take) m_drop[i] = 1'b1;
        if (i == 0 && take) acc_cnt++;
        m_p[i]  = m_p[i] + int'(take) - int'(iss);
        m_en[i] = iss;
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check ev_ready, let the
  // rising edge happen, then check the registered outputs on the next fall.
  task automatic step(input bit r, input bit v, input bit f);
    bit exp_rdy;
    rst      = r;
    ev_valid = v;
    cnt_full = f;
    #1;
    rdy_s[0] = ev_ready0;
    rdy_s[1] = ev_ready1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy = r && (DROP_MODE || m_p[i] < DEPTH);
      chk(i == 0 ? "ready0" : "ready1", int'(rdy_s[i]), int'(exp_rdy));
    end
    @(posedge clk);
    model_edge(r, v, f);
    n++;
    @(negedge clk);
    chk("en0", int'(en0), int'(m_en[0]));
    chk("en1", int'(en1), int'(m_en[1]));
    chk("pending0", int'(pending0), m_p[0]);
    chk("pending1", int'(pending1), m_p[1]);
`ifdef EVENT_PACER_DROP_EN
    chk("dropped0", int'(dropped0), int'(m_drop[0]));
    chk("dropped1", int'(dropped1), int'(m_drop[1]));
`endif
    en_cnt += int'(en0);
  endtask

  initial begin
    rst      = 1'b0;
    ev_valid = 1'b0;
    cnt_full = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_p[i] = 0; m_next[i] = 0; m_held[i] = 0; m_en[i] = 0; m_drop[i] = 0;
    end

    // Directed rows for the GAP=2 instance: {rst, valid, full, en, pending, ready}.
    // Single event, full stall of 3 events, then reset in the middle of WAIT.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd3, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};

    @(negedge clk);
    for (int k = 0; k < 18; k++) begin
      step(tbl[k].r, tbl[k].v, tbl[k].f);
      chk($sformatf("tbl%0d_ready", k), int'(rdy_s[0]), int'(tbl[k].e_rdy));
      chk($sformatf("tbl%0d_en", k), int'(en0), int'(tbl[k].e_en));
      chk($sformatf("tbl%0d_pending", k), int'(pending0), int'(tbl[k].e_p));
    end

    // GAP=1 instance: queue 4 events under cnt_full, then drain back-to-back.
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b1, 1'b1);
      chk($sformatf("g1_fill%0d", k), int'(pending1), k);
    end
`ifdef EVENT_PACER_DROP_EN
    step(1'b1, 1'b1, 1'b1);
    chk("drop_ready", int'(rdy_s[1]), 1);
    chk("drop_pending", int'(pending1), 4);
    chk("drop_flag", int'(dropped1), 1);
`else
    step(1'b1, 1'b1, 1'b1);
    chk("bp_ready", int'(rdy_s[1]), 0);
    chk("bp_pending", int'(pending1), 4);
`endif
    step(1'b1, 1'b0, 1'b0);
    chk("g1_unhold_en", int'(en1), 0);
    chk("g1_unhold_p", int'(pending1), 4);
    for (int k = 3; k >= 0; k--) begin
      step(1'b1, 1'b0, 1'b0);
      chk($sformatf("g1_drain_en%0d", k), int'(en1), 1);
      chk($sformatf("g1_drain_p%0d", k), int'(pending1), k);
    end
    step(1'b1, 1'b0, 1'b0);
    chk("g1_done_en", int'(en1), 0);
`ifdef EVENT_PACER_DROP_EN
    chk("drop_sticky", int'(dropped1), 1);
`endif

    // Burst on the GAP=2 instance: every accepted event yields one pulse.
    step(1'b0, 1'b0, 1'b0);
    acc_cnt = 0;
    en_cnt  = 0;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 14; k++) step(1'b1, 1'b0, 1'b0);
    chk("burst_count", en_cnt, acc_cnt);
    chk("burst_accepted", acc_cnt, 6);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 59) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/event_pacer.md
Name: event_pacer

Overview:
- Upstream feeder for the 4-bit event counter.
- Accepts event requests on a valid/ready handshake and queues them as a pending count.
- Emits one single-cycle `en` pulse per event, spaced at least GAP cycles apart.
- Stalls while the downstream counter reports `full`; its `cnt_full` input connects to the counter's `full` output.

Parameters:
- DEPTH, 4, maximum pending (accepted, not yet issued) events; legal range 1..15.
- GAP, 2, minimum spacing in clock cycles between `en` pulses; legal range 1..15.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- ev_valid  input  1  upstream event request.
- ev_ready  output  1  pacer can accept an event this cycle.
- cnt_full  input  1  downstream counter saturated; inhibits issue.
- en  output  1  registered one-cycle increment pulse to the counter.
- pending  output  4  current pending count P (0..DEPTH).
- dropped  output  1  sticky drop flag; present only with EVENT_PACER_DROP_EN.

Behaviour:
- Reset, sampled at posedge with rst==0:
  - P=0, en=0, state=IDLE, gap_cnt=0, dropped=0.
  - ev_ready is forced 0 while rst==0.
- Accept:
  - Occurs at a posedge where ev_valid && ev_ready.
  - ev_ready = rst && (P < DEPTH), combinational from registered P.
- State machine states: IDLE, WAIT, HOLD.
- IDLE:
  - If cnt_full==1 -> HOLD, no issue.
  - Else if P>0 -> issue: en<=1 for exactly one cycle, P decrements, gap_cnt<=GAP-1, next state WAIT (or IDLE if GAP==1).
  - Else stay IDLE, en<=0.
- WAIT:
  - en<=0, gap_cnt decrements each cycle.
  - When gap_cnt==1 at the edge -> IDLE.
  - cnt_full is ignored in WAIT.
- HOLD:
  - en<=0; stay while cnt_full==1.
  - First edge with cnt_full==0 -> IDLE; issue resumes at the following edge.
- Spacing and latency:
  - Consecutive `en` pulses are exactly GAP cycles apart when events are continuously pending and cnt_full==0.
  - GAP==1 gives back-to-back pulses.
  - Latency: an event accepted at edge t into an empty idle pacer produces en high in the cycle after edge t+1.
- Simultaneous accept and issue at the same edge: P unchanged.
- P==DEPTH: ev_ready=0. This holds even if an issue occurs at the same edge; no same-cycle pass-through.
- cnt_full rising while en is high: that pulse still completes; blocking applies from the next IDLE evaluation.
- Reset mid-operation: all pending events are discarded, the queue is not preserved, and en drops at that edge.
- Width rule: pending is zero-extended P. P never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: EVENT_PACER_DROP_EN.
- Defined:
  - ev_ready = rst (always ready out of reset).
  - An event presented when P==DEPTH with no issue at that edge is discarded and sets `dropped` to 1.
  - `dropped` is sticky and cleared only by reset.
  - If an issue happens at the same edge, the event is accepted and P stays DEPTH.
- Undefined: no `dropped` port; ev_ready = rst && (P < DEPTH); backpressure only, no event is ever lost.

Test Plan:
1. Reset then a single event (GAP=2): ev_valid one cycle at edge 1 -> pending=1 after edge 1, en high only after edge 2, pending=0, no further en.
2. Burst: ev_valid held for 6 cycles (DEPTH=4, GAP=2) -> ev_ready drops when pending reaches 4; en pulses every 2 cycles; total en count equals accepted handshakes.
3. GAP=1 with 4 queued events -> 4 consecutive-cycle en pulses; pending 4,3,2,1,0.
4. Full stall: 3 events pending and cnt_full held high 5 cycles -> en stays 0, pending stays 3; en resumes 2 edges after cnt_full falls.
5. Reset asserted (rst=0) with pending=3 mid-WAIT -> next cycle pending=0, en=0, ev_ready=0; after release ev_ready=1 and no en without new events.
6. EVENT_PACER_DROP_EN, DEPTH=4, cnt_full=1: 5 events -> pending=4, dropped=1 and stays 1 after cnt_full falls and all 4 pulses are issued.
